// File: rtl/aes_inv_round_ctrl_pkg.sv
// Shared types and constants for the AES inverse-cipher round sequencer:
// FSM state encoding, round counts per key length and key-length codes.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } aes_inv_state_e;

  localparam int unsigned AES_NR_128 = 10;
  localparam int unsigned AES_NR_192 = 12;
  localparam int unsigned AES_NR_256 = 14;

  typedef enum logic [1:0] {
    KEY_LEN_128  = 2'b00,
    KEY_LEN_192  = 2'b01,
    KEY_LEN_256  = 2'b10,
    KEY_LEN_RSVD = 2'b11
  } aes_key_len_e;

  // The reserved code falls back to AES-128 so a bad code can never over-run the key RAM.
  function automatic int unsigned aes_nr_from_key_len(input aes_key_len_e key_len);
    case (key_len)
      KEY_LEN_192: return AES_NR_192;
      KEY_LEN_256: return AES_NR_256;
      default:     return AES_NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// Handshake and round-control bundle between decrypt control, the sequencer
// and the inverse round datapath. i_key_len exists only with AES_INV_KEYLEN_EN.
interface aes_inv_round_ctrl_if #(
  parameter int CNT_SIZE = 4
);
  logic                i_start;
  logic                i_stall;
`ifdef AES_INV_KEYLEN_EN
  logic [1:0]          i_key_len;
`endif
  logic                o_ready;
  logic                o_busy;
  logic [CNT_SIZE-1:0] o_key_idx;
  logic                o_init;
  logic                o_mix_en;
  logic                o_final;
  logic                o_done;

  modport master (
    output i_start,
    output i_stall,
`ifdef AES_INV_KEYLEN_EN
    output i_key_len,
`endif
    input  o_ready,
    input  o_busy,
    input  o_key_idx,
    input  o_init,
    input  o_mix_en,
    input  o_final,
    input  o_done
  );

  modport slave (
    input  i_start,
    input  i_stall,
`ifdef AES_INV_KEYLEN_EN
    input  i_key_len,
`endif
    output o_ready,
    output o_busy,
    output o_key_idx,
    output o_init,
    output o_mix_en,
    output o_final,
    output o_done
  );

endinterface

// File: rtl/aes_inv_round_ctrl_counter.sv
// Round-key index down counter: load, saturating decrement, hold otherwise,
// with is_one/is_zero flags for the sequencer's exit decision.
module aes_round_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             is_one_o,
  output logic             is_zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign is_one_o  = (cnt_q == WIDTH'(1));
  assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// AES inverse-cipher round sequencer: counts the round-key index down from Nr to 0
// and decodes the per-round stage enables. AES_INV_KEYLEN_EN selects Nr per block.
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int MAX_CNT  = 10,
  parameter int CNT_SIZE = 4
) (
  input logic                clk,
  input logic                rst_n,
  aes_inv_round_ctrl_if.slave bus
);

  aes_inv_state_e      state_q;
  aes_inv_state_e      state_d;
  logic                advance;
  logic                cnt_load;
  logic                cnt_dec;
  logic [CNT_SIZE-1:0] nr_sel;
  logic [CNT_SIZE-1:0] key_idx;
  logic                key_is_one;
  logic                key_is_zero;

  // Nr is captured by the counter load on the start cycle, so later key-length changes are ignored.
`ifdef AES_INV_KEYLEN_EN
  assign nr_sel = CNT_SIZE'(aes_nr_from_key_len(aes_key_len_e'(bus.i_key_len)));
`else
  assign nr_sel = CNT_SIZE'(MAX_CNT);
`endif

  assign advance = !bus.i_stall;

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d  = ST_INIT;
          cnt_load = 1'b1;
        end
      end
      ST_INIT: begin
        if (advance) begin
          state_d = ST_ROUND;
          cnt_dec = 1'b1;
        end
      end
      ST_ROUND: begin
        // A zero index here is unreachable; exiting to FINAL keeps the FSM from ever wrapping.
        if (advance) begin
          cnt_dec = 1'b1;
          if (key_is_one || key_is_zero) begin
            state_d = ST_FINAL;
          end
        end
      end
      ST_FINAL: begin
        if (advance) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  aes_round_down_counter #(
    .WIDTH (CNT_SIZE)
  ) u_key_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (nr_sel),
    .dec_i      (cnt_dec),
    .cnt_o      (key_idx),
    .is_one_o   (key_is_one),
    .is_zero_o  (key_is_zero)
  );

  // Moore decode: each enable belongs to exactly one state, so they are mutually exclusive.
  always_comb begin
    bus.o_ready  = 1'b0;
    bus.o_busy   = 1'b0;
    bus.o_init   = 1'b0;
    bus.o_mix_en = 1'b0;
    bus.o_final  = 1'b0;
    bus.o_done   = 1'b0;
    case (state_q)
      ST_IDLE:  bus.o_ready = 1'b1;
      ST_INIT: begin
        bus.o_busy = 1'b1;
        bus.o_init = 1'b1;
      end
      ST_ROUND: begin
        bus.o_busy   = 1'b1;
        bus.o_mix_en = 1'b1;
      end
      ST_FINAL: begin
        bus.o_busy  = 1'b1;
        bus.o_final = 1'b1;
      end
      ST_DONE:  bus.o_done = 1'b1;
      default:  bus.o_ready = 1'b0;
    endcase
  end

  assign bus.o_key_idx = key_idx;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Scoreboard bench for aes_inv_round_ctrl: the driver queues the expected per-cycle
// outputs of each block, a negedge monitor pops and compares them.
module tb_aes_inv_round_ctrl;
  import aes_pkg::*;

  localparam int CNT_SIZE = 4;
  localparam int MAX_CNT  = 10;

  typedef struct {
    int         cyc;
    logic [4:0] flags;  // {busy, init, mix_en, final, done}
    logic [3:0] key;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cyc = -1;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_round_ctrl_if #(.CNT_SIZE(CNT_SIZE)) bus ();

  aes_inv_round_ctrl #(
    .MAX_CNT  (MAX_CNT),
    .CNT_SIZE (CNT_SIZE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [4:0] exp_flags(input int step, input int nr);
    return {step <= nr, step == 0, (step >= 1) && (step < nr), step == nr, step == nr + 1};
  endfunction

  function automatic logic [3:0] exp_key(input int step, input int nr);
    return (step <= nr) ? 4'(nr - step) : 4'd0;
  endfunction

  // Monitor: every busy/done cycle must match the next queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    check("enables_onehot0", 32'($countones({bus.o_init, bus.o_mix_en, bus.o_final, bus.o_done}) <= 1), 1);
    check("busy_ready_excl", 32'(bus.o_busy & bus.o_ready), 0);
    if (bus.o_busy || bus.o_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_cycle", cyc, e.cyc);
        check("out_flags", 32'({bus.o_busy, bus.o_init, bus.o_mix_en, bus.o_final, bus.o_done}), 32'(e.flags));
        check("out_key", 32'(bus.o_key_idx), 32'(e.key));
      end
      if (bus.o_done) done_cyc = cyc;
    end
  end

  // Steps: 0=INIT(key nr), 1..nr-1=ROUND(key nr-step), nr=FINAL(0), nr+1=DONE(0).
  task automatic run_block(input int nr, input logic [1:0] kl, input int stall_step,
                           input int stall_len, input bit rnd, input bit inject,
                           input int abort_step, output int start_cyc);
    int step = 0;
    int scnt = 0;
    bit st;
    start_cyc    = cyc;
    bus.i_start  = 1'b1;
`ifdef AES_INV_KEYLEN_EN
    bus.i_key_len = kl;
`endif
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    forever begin
`ifdef AES_INV_KEYLEN_EN
      bus.i_key_len = ~bus.i_key_len;
`endif
      st = 1'b0;
      if (step == stall_step && scnt < stall_len) begin
        st = 1'b1;
        scnt++;
      end else if (rnd && (cyc - start_cyc) < 60) begin
        st = 1'($urandom_range(0, 1));
      end
      bus.i_stall = st;
      bus.i_start = inject && (step == 3 || step == nr + 1);
      exp_q.push_back('{cyc, exp_flags(step, nr), exp_key(step, nr)});
      if (step == abort_step) begin
        @(negedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_stall = 1'b0;
        return;
      end
      if (step == nr + 1) break;
      if (!st) step++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_stall = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.o_ready), 1);
    check({tag, "_busy"}, 32'(bus.o_busy), 0);
    check({tag, "_key"}, 32'(bus.o_key_idx), 0);
    check({tag, "_enables"}, 32'({bus.o_init, bus.o_mix_en, bus.o_final, bus.o_done}), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int s;
    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_stall = 1'b0;
`ifdef AES_INV_KEYLEN_EN
    bus.i_key_len = 2'b00;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain block: INIT at +1, DONE at +12, ready again at +13.
    run_block(10, 2'b00, -1, 0, 1'b0, 1'b0, -1, s);
    @(negedge clk);
    check("plain_latency", done_cyc - s, 12);
    check("plain_ready_after", 32'(bus.o_ready), 1);

    // Three stall cycles while key 5 is shown (step 5): DONE at +15.
    run_block(10, 2'b00, 5, 3, 1'b0, 1'b0, -1, s);
    @(negedge clk);
    check("stall_latency", done_cyc - s, 15);

    // i_start pulsed in ROUND and in DONE is ignored; the monitor flags any restart.
    run_block(10, 2'b00, -1, 0, 1'b0, 1'b1, -1, s);
    repeat (3) @(negedge clk);
    check("inject_latency", done_cyc - s, 12);
    check("inject_stays_idle", 32'(bus.o_ready), 1);

    // Reset while key 4 is shown: immediate reset values, no DONE.
    done_cyc = -1;
    run_block(10, 2'b00, -1, 0, 1'b0, 1'b0, 6, s);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    check("midreset_queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_no_done", done_cyc, -1);
    @(posedge clk); #1;
    run_block(10, 2'b00, -1, 0, 1'b0, 1'b0, -1, s);
    @(negedge clk);
    check("post_reset_latency", done_cyc - s, 12);

    // Random stall patterns across several blocks.
    for (int b = 0; b < 4; b++) begin
      run_block(10, 2'b00, -1, 0, 1'b1, 1'b0, -1, s);
    end

`ifdef AES_INV_KEYLEN_EN
    run_block(14, 2'b10, -1, 0, 1'b0, 1'b0, -1, s);
    @(negedge clk);
    check("keylen256_latency", done_cyc - s, 16);
    run_block(12, 2'b01, -1, 0, 1'b0, 1'b0, -1, s);
    @(negedge clk);
    check("keylen192_latency", done_cyc - s, 14);
    run_block(10, 2'b11, -1, 0, 1'b0, 1'b0, -1, s);
    @(negedge clk);
    check("keylen_rsvd_latency", done_cyc - s, 12);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
